// File: rtl/csa_pkg.sv
// csa_pkg: shared constants and helpers for the pipelined carry-skip adder.
//   CSA_WIDTH / CSA_BLOCK : default operand width and skip-block width
//   csa_num_blocks()      : number of skip blocks, which is also the pipeline depth
package csa_pkg;

  localparam int CSA_WIDTH = 16;
  localparam int CSA_BLOCK = 4;

  function automatic int csa_num_blocks(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/carry_skip_adder_pipe_if.sv
// carry_skip_adder_pipe_if: operand/result handshake bundle for carry_skip_adder_pipe.
//   in_valid/in_ready   : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   master drives operands and accepts results; slave is the adder side.
interface carry_skip_adder_pipe_if #(
  parameter int WIDTH = csa_pkg::CSA_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csa_block.sv
// csa_block: one combinational carry-skip block.
//   a, b     : BLOCK-bit operand slices (b already inverted for subtraction)
//   ci       : carry into the block
//   s        : BLOCK-bit ripple sum
//   co       : carry out; bypasses the ripple chain when every bit propagates
//   c_msb_in : carry into the block's top bit (used for signed overflow)
module csa_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);
  logic [BLOCK:0] c;
  logic           p;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  // All bits propagate: the carry out is just the carry in, no need to wait on the ripple.
  assign p        = &(a ^ b);
  assign co       = p ? ci : c[BLOCK];
  assign c_msb_in = c[BLOCK-1];
endmodule

// File: rtl/carry_skip_adder_pipe.sv
// carry_skip_adder_pipe: pipelined carry-skip adder/subtractor, one stage per skip block.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : slave side of carry_skip_adder_pipe_if
//              in:  in_valid, a, b, cin, sub, out_ready
//              out: in_ready, out_valid, sum, cout, ovf
//   sub=0: sum = a + b + cin;  sub=1: sum = a - b (cin ignored, cout=1 means no borrow).
//   Latency NB = WIDTH/BLOCK cycles, one result per cycle; the whole pipe stalls on back-pressure.
module carry_skip_adder_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int BLOCK = CSA_BLOCK
) (
  input logic                    clk,
  input logic                    rst,
  carry_skip_adder_pipe_if.slave bus
);
  localparam int NB = csa_num_blocks(WIDTH, BLOCK);

  if (WIDTH % BLOCK != 0) begin : g_chk_div
    $error("carry_skip_adder_pipe: WIDTH must be a multiple of BLOCK");
  end
  if ($bits(bus.a) != WIDTH) begin : g_chk_if
    $error("carry_skip_adder_pipe: interface WIDTH does not match module WIDTH");
  end

  // Stage payload: operands travel with the slot so each stage only needs its own slice;
  // psum accumulates finished blocks from the bottom up.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             cmsb;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t q [NB];
  stage_t src0;
  stage_t last;
  logic   adv;

  assign last         = q[NB-1];
  assign adv          = !last.valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Subtraction is a + ~b + 1: invert b and force the carry in.
  always_comb begin
    src0       = '0;
    src0.valid = bus.in_valid;
    src0.carry = bus.sub ? 1'b1 : bus.cin;
    src0.a     = bus.a;
    src0.b     = bus.sub ? ~bus.b : bus.b;
  end

  for (genvar k = 0; k < NB; k++) begin : g_stg
    stage_t           prv;
    stage_t           nxt;
    logic [BLOCK-1:0] bs;
    logic             bco;
    logic             bcm;

    if (k == 0) begin : g_first
      assign prv = src0;
    end else begin : g_rest
      assign prv = q[k-1];
    end

    csa_block #(.BLOCK(BLOCK)) u_blk (
      .a        (prv.a[k*BLOCK +: BLOCK]),
      .b        (prv.b[k*BLOCK +: BLOCK]),
      .ci       (prv.carry),
      .s        (bs),
      .co       (bco),
      .c_msb_in (bcm)
    );

    always_comb begin
      nxt                         = prv;
      nxt.psum[k*BLOCK +: BLOCK]  = bs;
      nxt.carry                   = bco;
      nxt.cmsb                    = bcm;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)      q[k] <= '0;
      else if (adv) q[k] <= nxt;
    end
  end

  // Operands have no consumer past the last block.
  logic unused_last_ops;
  assign unused_last_ops = ^{last.a, last.b};

  assign bus.out_valid = last.valid;
  assign bus.sum       = last.psum;
  assign bus.cout      = last.carry;
  assign bus.ovf       = last.carry ^ last.cmsb;
endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
module tb_carry_skip_adder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  carry_skip_adder_pipe_if #(.WIDTH(16)) bus ();
  carry_skip_adder_pipe_if #(.WIDTH(4))  bus4 ();

  carry_skip_adder_pipe #(.WIDTH(16), .BLOCK(4)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  carry_skip_adder_pipe #(.WIDTH(4),  .BLOCK(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [17:0] sbq [$];
  logic        held = 1'b0;
  logic [18:0] prev_out;
  logic        done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Reference: plain integer arithmetic and signed-range overflow rules. Returns {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [16:0] r;
    logic        ov;
    if (sub) begin
      r[15:0] = a - b;
      r[16]   = (a >= b);
      ov      = (a[15] != b[15]) && (r[15] != a[15]);
    end else begin
      r  = 17'(a) + 17'(b) + 17'(cin);
      ov = (a[15] == b[15]) && (r[15] != a[15]);
    end
    return {ov, r};
  endfunction

  // Single compare process: handshake rule, output stability under stall, in-order results.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      held = 1'b0;
    end else begin
      chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (held)
        chk("stall_stable", {bus.out_valid, bus.ovf, bus.cout, bus.sum}, prev_out);
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got %h want none", {bus.ovf, bus.cout, bus.sum});
        end else begin
          chk("result", {bus.ovf, bus.cout, bus.sum}, sbq.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        sbq.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      held     = bus.out_valid && !bus.out_ready;
      prev_out = {bus.out_valid, bus.ovf, bus.cout, bus.sum};
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    int n = 0;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 60);
    if (!bus.in_ready) fail_now("send");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((sbq.size() != 0 || bus.out_valid) && n < 100) begin @(negedge clk); n++; end
    if (sbq.size() != 0) fail_now("drain");
    @(posedge clk); #1;
  endtask

  task automatic run_one(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [17:0] exp);
    int n = 0;
    bus.out_ready = 1'b1;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && n < 10) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, n, 4);
    chk(nm, {bus.ovf, bus.cout, bus.sum}, exp);
    @(posedge clk); #1;
  endtask

  logic [3:0] t4a   [5] = '{4'hF, 4'h7, 4'h3, 4'h8, 4'h0};
  logic [3:0] t4b   [5] = '{4'h1, 4'h1, 4'h5, 4'h1, 4'h0};
  logic       t4cin [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       t4sub [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [5:0] t4exp [5] = '{6'b010000, 6'b101000, 6'b001110, 6'b110111, 6'b000001};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout_ovf", {bus.cout, bus.ovf}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Hand-computed vectors
    run_one("add_1_1_c1",   16'h0001, 16'h0001, 1'b1, 1'b0, 18'h00003);
    run_one("skip_chain",   16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000});
    run_one("sub_ovf",      16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    run_one("sub_borrow",   16'h0003, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    run_one("add_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    run_one("sub_cin_ign",  16'h0005, 16'h0005, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0000});
    run_one("partial_skip", 16'h0FF0, 16'h0010, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000});

    // Back-pressure: 8 back-to-back ops, out_ready low for 5 cycles mid-stream
    base = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'(16'h1111 * i), 16'(16'h0F0F + i), i[0], i[1]);
        done = 1'b1;
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_out - base, 8);

    // Asynchronous reset with results in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.a = 16'(16'h0100 + i); bus.b = 16'h0203; bus.cin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    chk("mid_rst_pre_valid", bus.out_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_sum", bus.sum, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.out_valid) n++; end
    chk("mid_rst_no_stale", n, 0);
    @(posedge clk); #1;

    // Random traffic with random bubbles and back-pressure
    base = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          if (!done) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("rand_count", n_out - base, 300);

    // Single-stage configuration (WIDTH=4, BLOCK=4): latency 1
    for (int i = 0; i < 5; i++) begin
      bus4.a = t4a[i]; bus4.b = t4b[i]; bus4.cin = t4cin[i]; bus4.sub = t4sub[i]; bus4.in_valid = 1'b1;
      @(negedge clk);
      chk("nb1_in_ready", bus4.in_ready, 1);
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      @(negedge clk);
      chk("nb1_valid", bus4.out_valid, 1);
      chk("nb1_result", {bus4.ovf, bus4.cout, bus4.sum}, t4exp[i]);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("nb1_empty", bus4.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
